// File: rtl/sevenseg_word_seq.sv
// Stores a word of up to eight character codes and cycles through them on an
// active-low seven-segment display, with a per-character dwell and optional blank gap.
module sevenseg_word_seq #(
  parameter int unsigned DWELL_CYCLES = 12000000,
  parameter int unsigned GAP_CYCLES   = 3000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_char,
  input  logic       wr_last,
  input  logic       run,
  output logic       busy,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic [1:0] dbg_state
);

  // Write handshake: a character is taken on a rising edge where wr_valid and
  // wr_ready are both 1; wr_ready is high only while the sequencer is idle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counters load N-1 on entry so the state lasts exactly N cycles.
  localparam logic [23:0] DWELL_LOAD = 24'(DWELL_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD   = (GAP_CYCLES > 0) ? 24'(GAP_CYCLES - 1) : 24'd0;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d, idx_next;
  logic [23:0] cnt_q, cnt_d;
  logic [6:0]  seg_q, seg_d;
  logic [2:0]  wptr_q;
  logic [3:0]  len_q;
  logic [4:0]  word_mem [8];
  logic        wr_fire;

  // Active-high {a..g} pattern for a character code.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'h7E;
      5'd1:    glyph = 7'h30;
      5'd2:    glyph = 7'h6D;
      5'd3:    glyph = 7'h79;
      5'd4:    glyph = 7'h33;
      5'd5:    glyph = 7'h5B;
      5'd6:    glyph = 7'h5F;
      5'd7:    glyph = 7'h70;
      5'd8:    glyph = 7'h7F;
      5'd9:    glyph = 7'h7B;
      5'd10:   glyph = 7'h77;
      5'd11:   glyph = 7'h1F;
      5'd12:   glyph = 7'h4E;
      5'd13:   glyph = 7'h3D;
      5'd14:   glyph = 7'h4F;
      5'd15:   glyph = 7'h47;
      5'd17:   glyph = 7'h37;
      5'd18:   glyph = 7'h0E;
      5'd19:   glyph = 7'h67;
      5'd20:   glyph = 7'h3E;
      5'd21:   glyph = 7'h01;
      default: glyph = 7'h00;
    endcase
  endfunction

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_fire   = wr_valid && wr_ready;
  assign dbg_state = state_q;
  assign {a, b, c, d, e, f, g} = seg_q;

  assign idx_next = ({1'b0, idx_q} == (len_q - 4'd1)) ? 3'd0 : idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        seg_d = SEG_BLANK;
        // A write in the same cycle wins; the word may be changing under us.
        if (run && (len_q != 4'd0) && !wr_fire) begin
          state_d = SHOW;
          idx_d   = 3'd0;
          cnt_d   = DWELL_LOAD;
          seg_d   = ~glyph(word_mem[0]);
        end
      end
      SHOW: begin
        if (!run) begin
          state_d = IDLE;
          seg_d   = SEG_BLANK;
        end else if (cnt_q == 24'd0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
            seg_d   = SEG_BLANK;
          end else begin
            idx_d = idx_next;
            cnt_d = DWELL_LOAD;
            seg_d = ~glyph(word_mem[idx_next]);
          end
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      GAP: begin
        if (!run) begin
          state_d = IDLE;
          seg_d   = SEG_BLANK;
        end else if (cnt_q == 24'd0) begin
          state_d = SHOW;
          idx_d   = idx_next;
          cnt_d   = DWELL_LOAD;
          seg_d   = ~glyph(word_mem[idx_next]);
        end else begin
          cnt_d = cnt_q - 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        seg_d   = SEG_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 24'd0;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
    end
  end

  // Word length becomes visible only once the word is closed, so a partial
  // word never gets displayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= 3'd0;
      len_q  <= 4'd0;
    end else if (wr_fire) begin
      if (wr_last || (wptr_q == 3'd7)) begin
        len_q  <= {1'b0, wptr_q} + 4'd1;
        wptr_q <= 3'd0;
      end else begin
        wptr_q <= wptr_q + 3'd1;
        if (wptr_q == 3'd0) begin
          len_q <= 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      word_mem[wptr_q] <= wr_char;
    end
  end

endmodule

// File: doc/sevenseg_word_seq.md
SEVENSEG_WORD_SEQ -- requirements
Module: sevenseg_word_seq

Interface
REQ-001 Parameter DWELL_CYCLES, default 12000000, clock cycles each character is shown (minimum 1).
REQ-002 Parameter GAP_CYCLES, default 3000000, clock cycles of blank between characters (0 = no gap).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  character write request.
REQ-006 wr_ready  output  1  write accepted when wr_valid && wr_ready at a rising clk edge.
REQ-007 wr_char  input  5  character code.
REQ-008 wr_last  input  1  marks the final character of the word.
REQ-009 run  input  1  level; 1 = cycle through the stored word, 0 = stop and blank.
REQ-010 busy  output  1  1 in SHOW or GAP.
REQ-011 a, b, c, d, e, f, g  output  1 each  segment drives, active-low (0 = lit), registered.

Function
REQ-012 Word buffer: 8 entries x 5 bits; write pointer wptr (3 bits); latched length len (0..8).
REQ-013 FSM states: IDLE, SHOW, GAP.
REQ-014 wr_ready = 1 only in IDLE.
REQ-015 Accepted write stores wr_char at wptr; a write with wptr==0 first clears len to 0.
REQ-016 Accepted write with wr_last=1 or wptr==7: len <= wptr+1, wptr <= 0; otherwise wptr <= wptr+1.
REQ-017 IDLE -> SHOW with idx=0 when run=1, len!=0 and no write is accepted that cycle; an accepted write takes priority and the FSM stays in IDLE.
REQ-018 SHOW: segments show glyph(buf[idx]) for exactly DWELL_CYCLES cycles, then GAP if GAP_CYCLES>0, else SHOW with the next idx.
REQ-019 GAP: segments blank for exactly GAP_CYCLES cycles, then SHOW with the next idx.
REQ-020 Next idx = idx+1, wrapping to 0 when idx==len-1; len==1 repeats buf[0].
REQ-021 run=0 in SHOW or GAP -> IDLE on the next edge; segments blank from that edge; buffer, len and wptr are kept.
REQ-022 Dwell/gap counter is 24 bits, loaded on every state entry, and counts down to the transition; no off-by-one: a character's visible period equals DWELL_CYCLES cycles.
REQ-023 Segment outputs are registered and change on the same edge as the state change (zero added latency).
REQ-024 Glyph table, active-high {a..g}, inverted at the output:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B
  - A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - 16 blank=00, 17 H=37, 18 L=0E, 19 P=67, 20 U=3E, 21 '-'=01
  - 22..31 blank
REQ-025 Blank means all seven outputs = 1.
REQ-026 A partial word (writes without wr_last, wptr!=0) leaves len=0, so run has no effect until the word is completed.

Reset
REQ-027 While rst_n=0:
  - state=IDLE, idx=0, wptr=0, len=0, counter=0
  - a..g=1 (blank), busy=0, wr_ready=1
  - buffer contents don't-care
REQ-028 Reset asserted mid-SHOW/GAP blanks the outputs immediately (asynchronously) and clears len; after release the word must be reloaded.

Verification
REQ-029 Bench uses DWELL_CYCLES=4, GAP_CYCLES=2.
REQ-030 Load codes 17,14,18,18,0 (wr_last on 0), then run=1 -> repeating pattern: H 4 cycles, blank 2, E, blank, L, blank, L, blank, 0, blank, then H again. Active-low outputs: H = 7'b1001000, 0 = 7'b0000001.
REQ-031 Load a single char 5 with wr_last and GAP_CYCLES=0 build -> a..g held at 7'b0100100 continuously while run=1; busy=1.
REQ-032 Write 8 chars without wr_last -> len=8 after the 8th, wptr=0; the 9th write starts a new word (len=0 until completed).
REQ-033 run=0 during the 3rd cycle of SHOW -> next edge IDLE, a..g=7'h7F, busy=0, wr_ready=1; run=1 again restarts at idx 0.
REQ-034 wr_valid and run both asserted in IDLE with len=3 -> write accepted, FSM remains IDLE that cycle, SHOW begins the following cycle if run is still 1; rst_n pulsed low mid-GAP -> outputs blank at once, len=0.
